// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes one active-low row at a time, debounces whole
// scan frames and reports a linear key index with press/release strobes.
module keypad_scanner #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 200000,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned KEY_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_en,
  input  logic [COLS-1:0]  column,
  output logic [ROWS-1:0]  row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_release,
  output logic             key_held,
  output logic             multi_key
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned DB_W  = 4;

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_e;
  typedef enum logic {S_IDLE, S_HELD} state_e;

  logic [COLS-1:0]  r_sync1, r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [ROW_W-1:0] r_row_idx, w_row_idx_nxt;
  logic [ROWS-1:0]  r_row;
  logic             w_tick, w_frame_end;

  logic [1:0]       w_row_cnt, r_acc_cnt, w_acc_cnt;
  logic [2:0]       w_sum;
  logic             w_row_hit;
  logic [KEY_W-1:0] w_row_col, r_acc_idx, w_acc_idx;

  res_e             w_res, r_prev_res;
  logic [KEY_W-1:0] r_prev_idx;
  logic [DB_W-1:0]  r_db_cnt, w_db_nxt;
  logic             w_same, w_qual;

  state_e           r_state, w_state_nxt;
  logic [KEY_W-1:0] r_key_code, w_code_nxt;
  logic             r_valid, w_valid_nxt, r_release, w_release_nxt;
  logic             r_held, w_held_nxt, r_multi, w_multi_nxt;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= column;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick        = scan_en && (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end   = w_tick && (r_row_idx == ROW_W'(ROWS - 1));
  assign w_row_idx_nxt = (r_row_idx == ROW_W'(ROWS - 1)) ? '0 : r_row_idx + ROW_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_row_idx <= '0;
      r_row     <= ~ROWS'(1);
    end else if (w_tick) begin
      r_div     <= '0;
      r_row_idx <= w_row_idx_nxt;
      r_row     <= ~(ROWS'(1) << w_row_idx_nxt);
    end else if (scan_en) begin
      r_div     <= r_div + DIV_W'(1);
    end
  end

  // Low-column count (saturating at 2) and lowest pressed column of this row
  always_comb begin
    w_row_cnt = 2'd0;
    w_row_hit = 1'b0;
    w_row_col = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!r_sync2[c]) begin
        if (w_row_cnt != 2'd2) w_row_cnt = w_row_cnt + 2'd1;
        if (!w_row_hit) begin
          w_row_hit = 1'b1;
          w_row_col = KEY_W'(c);
        end
      end
    end
  end

  assign w_sum     = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
  assign w_acc_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_acc_idx = (r_acc_cnt == 2'd0 && w_row_hit) ?
                     KEY_W'(r_row_idx) * KEY_W'(COLS) + w_row_col : r_acc_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc_cnt <= '0;
      r_acc_idx <= '0;
    end else if (w_frame_end) begin
      r_acc_cnt <= '0;
      r_acc_idx <= '0;
    end else if (w_tick) begin
      r_acc_cnt <= w_acc_cnt;
      r_acc_idx <= w_acc_idx;
    end
  end

  assign w_res = (w_acc_cnt == 2'd0) ? RES_NONE :
                 (w_acc_cnt == 2'd1) ? RES_KEY  : RES_MULTI;

  // Frame-to-frame debounce counter; MULTI never qualifies
  always_comb begin
    w_same = (w_res == r_prev_res) && (w_res != RES_KEY || w_acc_idx == r_prev_idx);
    if (w_res == RES_MULTI)
      w_db_nxt = '0;
    else if (w_same)
      w_db_nxt = (r_db_cnt == DB_W'(DEBOUNCE)) ? r_db_cnt : r_db_cnt + DB_W'(1);
    else
      w_db_nxt = DB_W'(1);
    w_qual = (w_db_nxt == DB_W'(DEBOUNCE));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev_res <= RES_NONE;
      r_prev_idx <= '0;
      r_db_cnt   <= '0;
    end else if (w_frame_end) begin
      r_prev_res <= w_res;
      r_prev_idx <= w_acc_idx;
      r_db_cnt   <= w_db_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_end && w_qual) begin
      case (r_state)
        S_IDLE:  if (w_res == RES_KEY)  w_state_nxt = S_HELD;
        S_HELD:  if (w_res == RES_NONE) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; strobes default low
  always_comb begin
    w_valid_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_code_nxt    = r_key_code;
    w_held_nxt    = r_held;
    w_multi_nxt   = r_multi;
    if (w_frame_end) begin
      w_multi_nxt = (w_res == RES_MULTI);
      case (r_state)
        S_IDLE: begin
          if (w_res == RES_KEY && w_qual) begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_acc_idx;
            w_held_nxt  = 1'b1;
          end
        end
        S_HELD: begin
          if (w_res == RES_NONE && w_qual) begin
            w_release_nxt = 1'b1;
            w_held_nxt    = 1'b0;
          end else if (w_res == RES_KEY && w_qual && w_acc_idx != r_key_code) begin
            w_release_nxt = 1'b1;
            w_valid_nxt   = 1'b1;
            w_code_nxt    = w_acc_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key_code <= '0;
      r_valid    <= 1'b0;
      r_release  <= 1'b0;
      r_held     <= 1'b0;
      r_multi    <= 1'b0;
    end else begin
      r_key_code <= w_code_nxt;
      r_valid    <= w_valid_nxt;
      r_release  <= w_release_nxt;
      r_held     <= w_held_nxt;
      r_multi    <= w_multi_nxt;
    end
  end

  assign row         = r_row;
  assign key_code    = r_key_code;
  assign key_valid   = r_valid;
  assign key_release = r_release;
  assign key_held    = r_held;
  assign multi_key   = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives columns from a pressed-key mask,
// and a frame-level reference model predicts strobes, code, held and multi flags.
module tb_keypad_scanner;

  localparam int unsigned ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, KEY_W = 4;
  localparam int FRAME = ROWS * SCAN_DIV;
  localparam int DB    = 2;
  localparam int MULTI = 100;

  typedef struct packed {
    logic       valid;
    logic       rel;
    logic       held;
    logic       multi;
    logic [3:0] code;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset_n, scan_en;
  logic [COLS-1:0]  column;
  logic [ROWS-1:0]  row;
  logic [KEY_W-1:0] key_code;
  logic             key_valid, key_release, key_held, multi_key;
  logic [15:0]      mask;

  int   total = 0, bad = 0;
  int   m_prev, m_cnt;
  logic m_held;
  logic [3:0] m_code;
  obs_t exp_o, obs_o;
  int   obs_cycles, obs_glitch;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                   .DEBOUNCE(DEBOUNCE), .KEY_W(KEY_W)) dut (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .column(column),
    .row(row), .key_code(key_code), .key_valid(key_valid),
    .key_release(key_release), .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key pulls its column low while its row is driven low
  always_comb begin
    column = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mask[r*COLS+c] && !row[r]) column[c] = 1'b0;
  end

  task automatic model_reset();
    m_prev = -1; m_cnt = 0; m_held = 1'b0; m_code = 4'd0; exp_o = '0;
  endtask

  // One whole frame seen with a constant mask: NONE (-1), key index, or MULTI
  task automatic model_step(input logic [15:0] mk);
    int res, n;
    n = $countones(mk);
    if (n == 0) res = -1;
    else if (n == 1) begin
      res = 0;
      for (int k = 0; k < 16; k++) if (mk[k]) res = k;
    end else res = MULTI;
    if (res == MULTI)       m_cnt = 0;
    else if (res == m_prev) m_cnt = (m_cnt < DB) ? m_cnt + 1 : m_cnt;
    else                    m_cnt = 1;
    m_prev = res;
    exp_o.valid = 1'b0;
    exp_o.rel   = 1'b0;
    exp_o.multi = (res == MULTI);
    if (res != MULTI && m_cnt == DB) begin
      if (!m_held && res >= 0) begin
        exp_o.valid = 1'b1; m_held = 1'b1; m_code = 4'(res);
      end else if (m_held && res < 0) begin
        exp_o.rel = 1'b1; m_held = 1'b0;
      end else if (m_held && res >= 0 && 4'(res) != m_code) begin
        exp_o.rel = 1'b1; exp_o.valid = 1'b1; m_code = 4'(res);
      end
    end
    exp_o.held = m_held;
    exp_o.code = m_code;
  endtask

  // Apply a mask for one frame (optionally freezing scan_en 50 cycles mid-frame),
  // then capture the outputs on the cycle right after the frame-end tick.
  task automatic run_frame(input logic [15:0] mk, input int freeze_at);
    logic [3:0] prev, frozen_row;
    mask = mk; obs_cycles = 0; obs_glitch = 0;
    prev = row;
    for (int n = 1; n <= 200; n++) begin
      if (n - 1 == freeze_at) begin
        scan_en = 1'b0; frozen_row = row;
        repeat (50) begin
          @(negedge clk); obs_cycles++;
          if (row !== frozen_row || key_valid !== 1'b0 || key_release !== 1'b0) obs_glitch++;
        end
        scan_en = 1'b1; prev = row;
      end
      @(negedge clk); obs_cycles++;
      if (prev == 4'b0111 && row == 4'b1110) break;
      if (key_valid !== 1'b0 || key_release !== 1'b0) obs_glitch++;
      prev = row;
    end
    obs_o = {key_valid, key_release, key_held, multi_key, key_code};
  endtask

  task automatic check_frame(input string name, input int idx, input int exp_cycles);
    total++;
    if (obs_o !== exp_o) begin
      bad++;
      $display("FAIL %s frame %0d: got v=%b r=%b h=%b m=%b code=%0d, want v=%b r=%b h=%b m=%b code=%0d",
               name, idx, obs_o.valid, obs_o.rel, obs_o.held, obs_o.multi, obs_o.code,
               exp_o.valid, exp_o.rel, exp_o.held, exp_o.multi, exp_o.code);
    end
    total++;
    if (obs_cycles != exp_cycles || obs_glitch != 0) begin
      bad++;
      $display("FAIL %s frame %0d timing: got cycles=%0d glitches=%0d, want cycles=%0d glitches=0",
               name, idx, obs_cycles, obs_glitch, exp_cycles);
    end
  endtask

  task automatic test_reset();
    int row_err, out_err;
    reset_n = 1'b0; scan_en = 1'b1; mask = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({row, key_valid, key_release, key_held, multi_key, key_code} !== {4'b1110, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: got row=%b v=%b r=%b h=%b m=%b code=%0d, want row=1110 all 0",
               row, key_valid, key_release, key_held, multi_key, key_code);
    end
    reset_n = 1'b1; model_reset();
    row_err = 0; out_err = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (row !== ~(4'b0001 << ((k / SCAN_DIV) % ROWS))) row_err++;
      if ({key_valid, key_release, key_held, multi_key, key_code} !== 8'h00) out_err++;
    end
    model_step('0); model_step('0);
    total++;
    if (row_err != 0) begin
      bad++; $display("FAIL idle_row_sequence: got %0d wrong cycles, want 0", row_err);
    end
    total++;
    if (out_err != 0) begin
      bad++; $display("FAIL idle_outputs: got %0d nonzero cycles, want 0", out_err);
    end
  endtask

  task automatic test_single_press();
    logic [15:0] seq [5];
    seq = '{16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      run_frame(seq[i], -1); model_step(seq[i]); check_frame("single_press", i, FRAME);
    end
    total++;
    if (key_code !== 4'd6 || key_held !== 1'b0) begin
      bad++; $display("FAIL single_after_release: got code=%0d held=%b, want code=6 held=0", key_code, key_held);
    end
  endtask

  task automatic test_bounce();
    int valids;
    valids = 0;
    for (int i = 0; i < 6; i++) begin
      run_frame((i % 2 == 0) ? 16'h0200 : 16'h0000, -1);
      model_step((i % 2 == 0) ? 16'h0200 : 16'h0000);
      check_frame("bounce", i, FRAME);
      if (obs_o.valid) valids++;
    end
    total++;
    if (valids != 0) begin
      bad++; $display("FAIL bounce_no_valid: got %0d key_valid pulses, want 0", valids);
    end
  endtask

  task automatic test_multi_rollover();
    logic [15:0] seq [8];
    seq = '{16'h8001, 16'h8001, 16'h8000, 16'h8000, 16'h0008, 16'h0008, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      run_frame(seq[i], -1); model_step(seq[i]); check_frame("multi_rollover", i, FRAME);
    end
  endtask

  task automatic test_freeze();
    logic [15:0] seq [4];
    seq = '{16'h0020, 16'h0020, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      run_frame(seq[i], (i == 0) ? 5 : -1);
      model_step(seq[i]);
      check_frame("freeze", i, (i == 0) ? FRAME + 50 : FRAME);
    end
  endtask

  task automatic test_reset_mid_debounce();
    run_frame(16'h0400, -1); model_step(16'h0400); check_frame("reset_mid_pre", 0, FRAME);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({row, key_valid, key_release, key_held, multi_key, key_code} !== {4'b1110, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid_cleared: got row=%b v=%b r=%b h=%b m=%b code=%0d, want row=1110 all 0",
               row, key_valid, key_release, key_held, multi_key, key_code);
    end
    reset_n = 1'b1; model_reset();
    for (int i = 0; i < 4; i++) begin
      run_frame((i < 2) ? 16'h0400 : 16'h0000, -1);
      model_step((i < 2) ? 16'h0400 : 16'h0000);
      check_frame("reset_mid_post", i, FRAME);
    end
  endtask

  task automatic test_random();
    logic [15:0] mk;
    int kind, k, k2, hold;
    for (int s = 0; s < 25; s++) begin
      kind = $urandom_range(0, 3);
      k    = $urandom_range(0, 15);
      k2   = (k + $urandom_range(1, 15)) % 16;
      if (kind == 0)      mk = '0;
      else if (kind < 3)  mk = 16'(1) << k;
      else                mk = (16'(1) << k) | (16'(1) << k2);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        run_frame(mk, -1); model_step(mk); check_frame("random", s, FRAME);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_rollover();
    test_freeze();
    test_reset_mid_debounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
